// File: rtl/plab4_net_router_input_ctrl_arb_rr.sv
// Router input-port controller: routes each domain's head message and picks one
// domain per cycle round-robin, optionally holding the pick until its message transfers.
module plab4_net_router_input_ctrl_arb_rr #(
    parameter int         p_router_id    = 0,
    parameter int         p_num_routers  = 8,
    parameter int         p_num_domains  = 4,
    parameter logic [2:0] p_default_reqs = 3'b001,
    parameter int         p_hold         = 1,
    localparam int        c_dest_nbits   = $clog2(p_num_routers),
    localparam int        c_dom_nbits    = $clog2(p_num_domains)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [p_num_domains*c_dest_nbits-1:0] dest,
    input  logic [p_num_domains-1:0]              in_val,
    output logic [p_num_domains-1:0]              in_rdy,
    output logic [2:0]                            reqs,
    input  logic [2:0]                            grants,
    output logic [c_dom_nbits-1:0]                domain,
    output logic                                  domain_val
);

    logic [p_num_domains-1:0][2:0] rq;
    logic [p_num_domains-1:0]      act;

    logic [c_dom_nbits-1:0] rr_ptr_q, rr_ptr_d;
    logic                   lock_q, lock_d;
    logic [c_dom_nbits-1:0] sel_q, sel_d;

    logic [c_dom_nbits-1:0] sel;
    logic                   fire;

    // Per-domain route: local destinations eject on p1, everything else uses the default.
    generate
        for (genvar gi = 0; gi < p_num_domains; gi++) begin : g_route
            logic [c_dest_nbits-1:0] dest_k;
            assign dest_k = dest[gi*c_dest_nbits +: c_dest_nbits];
            assign rq[gi] = !in_val[gi]                 ? 3'b000 :
                            (int'(dest_k) == p_router_id) ? 3'b010 :
                                                            p_default_reqs;
            assign act[gi] = |rq[gi];
        end
    endgenerate

    // A held domain that drops in_val loses the lock immediately, falling back to the search.
    always_comb begin
        logic found;
        int   idx;
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        if ((p_hold != 0) && lock_q && act[sel_q]) begin
            sel = sel_q;
        end else begin
            for (int i = 0; i < p_num_domains; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= p_num_domains) idx = idx - p_num_domains;
                if (!found && act[idx]) begin
                    found = 1'b1;
                    sel   = c_dom_nbits'(idx);
                end
            end
        end
    end

    assign domain_val = |act;
    assign domain     = sel;
    assign reqs       = (domain_val && !reset) ? rq[sel] : 3'b000;

    generate
        for (genvar gi = 0; gi < p_num_domains; gi++) begin : g_rdy
            assign in_rdy[gi] = !reset && (int'(sel) == gi) && domain_val
                                && (|(rq[gi] & grants));
        end
    endgenerate

    assign fire = |(in_val & in_rdy);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        lock_d   = 1'b0;
        sel_d    = sel_q;
        if (fire) begin
            rr_ptr_d = (int'(sel) == p_num_domains - 1) ? '0 : sel + 1'b1;
        end else if (domain_val && (p_hold != 0)) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            sel_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            sel_q    <= sel_d;
        end
    end

endmodule
